// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator driven by a pixel-enable tick
// Outputs are registered from the next counter values so coordinates and syncs never skew.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_q, video_d;
    logic       frame_q, frame_d;

    // Wrap counters: v only moves when h wraps, frame_start only on the full (0,0) wrap.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = 1'b0;
        if (tick) begin
            if (h_q == H_MAX) begin
                h_d = 10'd0;
                if (v_q == V_MAX) begin
                    v_d     = 10'd0;
                    frame_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_comb begin
        video_d = (h_d < H_VIS) && (v_d < V_VIS);
        hsync_d = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            video_q <= 1'b1;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            video_q <= video_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            frame_q <= frame_d;
        end
    end

    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign video_on    = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen (default timing plus a tiny SYNC_POL=1 raster)
module tb_vga_sync_gen;

    localparam int AHD = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVD = 480, AVF = 10, AVS = 2, AVB = 33;
    localparam int AHT = AHD + AHF + AHS + AHB;
    localparam int AVT = AVD + AVF + AVS + AVB;
    localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVD = 6, BVF = 1, BVS = 2, BVB = 1;
    localparam int BHT = BHD + BHF + BHS + BHB;
    localparam int BVT = BVD + BVF + BVS + BVB;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       tick   = 1'b0;
    logic       a_hsync, a_vsync, a_video_on, a_frame_start;
    logic [9:0] a_pixel_x, a_pixel_y;
    logic       b_hsync, b_vsync, b_video_on, b_frame_start;
    logic [9:0] b_pixel_x, b_pixel_y;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       fs;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;
    int   ah = 0, av = 0, bh = 0, bv = 0;
    int   a_hs_low = 0;
    int   b_fs_cnt = 0;

    vga_sync_gen dut_a (
        .clk_in(clk_in), .reset(reset), .tick(tick),
        .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
        .pixel_x(a_pixel_x), .pixel_y(a_pixel_y), .frame_start(a_frame_start)
    );

    vga_sync_gen #(
        .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk_in(clk_in), .reset(reset), .tick(tick),
        .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
        .pixel_x(b_pixel_x), .pixel_y(b_pixel_y), .frame_start(b_frame_start)
    );

    always #5 clk_in = ~clk_in;

    function automatic exp_t model(input int h, input int v, input int hd, input int hf,
                                   input int hs, input int vd, input int vf, input int vs,
                                   input bit pol, input bit fs);
        exp_t r;
        r.x   = 10'(h);
        r.y   = 10'(v);
        r.vid = (h < hd) && (v < vd);
        r.hs  = (h >= hd + hf && h < hd + hf + hs) ? pol : ~pol;
        r.vs  = (v >= vd + vf && v < vd + vf + vs) ? pol : ~pol;
        r.fs  = fs;
        return r;
    endfunction

    task automatic check10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input bit t, input bit r);
        bit   fa, fb;
        exp_t ea, eb;
        @(negedge clk_in);
        tick  = t;
        reset = r;
        fa = 1'b0;
        fb = 1'b0;
        if (r) begin
            ah = 0; av = 0; bh = 0; bv = 0;
        end else if (t) begin
            if (ah == AHT - 1) begin
                ah = 0;
                if (av == AVT - 1) begin av = 0; fa = 1'b1; end else av++;
            end else ah++;
            if (bh == BHT - 1) begin
                bh = 0;
                if (bv == BVT - 1) begin bv = 0; fb = 1'b1; end else bv++;
            end else bh++;
        end
        qa.push_back(model(ah, av, AHD, AHF, AHS, AVD, AVF, AVS, 1'b0, fa));
        qb.push_back(model(bh, bv, BHD, BHF, BHS, BVD, BVF, BVS, 1'b1, fb));
        @(posedge clk_in);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check10("a_pixel_x", a_pixel_x, ea.x);
        check10("a_pixel_y", a_pixel_y, ea.y);
        check1("a_hsync", a_hsync, ea.hs);
        check1("a_vsync", a_vsync, ea.vs);
        check1("a_video_on", a_video_on, ea.vid);
        check1("a_frame_start", a_frame_start, ea.fs);
        check10("b_pixel_x", b_pixel_x, eb.x);
        check10("b_pixel_y", b_pixel_y, eb.y);
        check1("b_hsync", b_hsync, eb.hs);
        check1("b_vsync", b_vsync, eb.vs);
        check1("b_video_on", b_video_on, eb.vid);
        check1("b_frame_start", b_frame_start, eb.fs);
        if (a_hsync == 1'b0) a_hs_low++;
        if (b_frame_start == 1'b1) b_fs_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        // Reset, including reset overriding a simultaneous tick.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check10("rst_x", a_pixel_x, 10'd0);
        check10("rst_y", a_pixel_y, 10'd0);
        check1("rst_video", a_video_on, 1'b1);
        check1("rst_hsync", a_hsync, 1'b1);
        check1("rst_vsync", a_vsync, 1'b1);
        check1("rst_frame", a_frame_start, 1'b0);
        check1("rst_b_hsync", b_hsync, 1'b0);
        check1("rst_b_vsync", b_vsync, 1'b0);

        // Continuous ticks over one full default line.
        a_hs_low = 0;
        for (int i = 1; i <= AHT; i++) begin
            step(1'b1, 1'b0);
            if (i == 639) check1("video_last", a_video_on, 1'b1);
            if (i == 640) check1("video_fall", a_video_on, 1'b0);
            if (i == 655) check1("hs_before", a_hsync, 1'b1);
            if (i == 656) check1("hs_fall", a_hsync, 1'b0);
            if (i == 751) check1("hs_last", a_hsync, 1'b0);
            if (i == 752) check1("hs_rise", a_hsync, 1'b1);
            if (i == 799) begin
                check10("line_end_x", a_pixel_x, 10'd799);
                check10("line_end_y", a_pixel_y, 10'd0);
            end
        end
        check_int("hs_low_cycles", a_hs_low, 96);
        check10("wrap_x", a_pixel_x, 10'd0);
        check10("wrap_y", a_pixel_y, 10'd1);

        // Divider-rate ticks: one per 1000 cycles, counters hold in between.
        for (int p = 0; p < 5; p++) begin
            repeat (999) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        check10("div_x", a_pixel_x, 10'd5);

        // Mid-line reset with tick high restarts at (0,0) without frame_start.
        repeat (295) step(1'b1, 1'b0);
        check10("pre_rst_x", a_pixel_x, 10'd300);
        step(1'b1, 1'b1);
        check10("mid_rst_x", a_pixel_x, 10'd0);
        check10("mid_rst_y", a_pixel_y, 10'd0);
        check1("mid_rst_video", a_video_on, 1'b1);
        check1("mid_rst_hs", a_hsync, 1'b1);
        check1("mid_rst_vs", a_vsync, 1'b1);
        check1("mid_rst_fs", a_frame_start, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        check10("resume_x", a_pixel_x, 10'd10);

        // Random tick gaps over exactly two small frames.
        step(1'b0, 1'b1);
        b_fs_cnt = 0;
        for (int i = 0; i < 2 * BHT * BVT; i++) begin
            repeat ($urandom_range(0, 7)) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0);
        check_int("b_frame_pulses", b_fs_cnt, 2);
        check10("b_end_x", b_pixel_x, 10'd0);
        check10("b_end_y", b_pixel_y, 10'd0);
        check10("a_end_x", a_pixel_x, 10'd300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the single-cycle pixel-enable `tick` from the pixel clock divider.
- Produces VGA raster timing: hsync, vsync, active-video flag, current pixel coordinates and a frame-start pulse.
- Runs entirely in the `clk_in` domain. `tick` is a clock enable, never a clock.
- Sits between the divider and the pixel/character renderer that drives the display.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk_in  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  pixel enable; one pixel step per clk_in cycle where tick=1
- hsync  output  1  horizontal sync, active level = SYNC_POL
- vsync  output  1  vertical sync, active level = SYNC_POL
- video_on  output  1  1 when the current position is inside the visible area
- pixel_x  output  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  output  10  current vertical count, 0..V_TOTAL-1
- frame_start  output  1  one-clk_in-cycle pulse when the position wraps to (0,0)

Behaviour:
- Interface: one clock (clk_in). reset is synchronous and active-high, sampled only on the rising edge of clk_in.
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
  - Both must fit in 10 bits.
- Horizontal counter h:
  - Advances only on edges where tick=1 and reset=0.
  - h = H_TOTAL-1 with tick -> h wraps to 0 and v advances.
- Vertical counter v:
  - v = V_TOTAL-1 at an h wrap -> v wraps to 0.
  - v never changes except at an h wrap.
- tick=0: counters and all outputs hold, except frame_start, which is 0.
- tick held high continuously: position advances every clk_in cycle. No minimum tick spacing is required.
- Output timing:
  - All outputs are registers updated on the same edge as the counters, decoded from the next counter values.
  - pixel_x/pixel_y are always consistent with hsync/vsync/video_on. Zero-cycle skew between them.
- Decode:
  - video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
  - hsync active for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC (default 656..751).
  - vsync active for V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC (default 490..491).
  - Inactive sync level = ~SYNC_POL.
- frame_start:
  - Asserted for exactly one clk_in cycle, following the edge where (h,v) goes from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Not asserted on reset.
- Reset:
  - h=0, v=0, pixel_x=0, pixel_y=0, video_on=1 (position (0,0) is visible).
  - hsync=vsync=~SYNC_POL, frame_start=0.
  - reset overrides a simultaneous tick.
  - Reset mid-frame restarts at (0,0) on the next edge, with no frame_start pulse.
- Arithmetic: unsigned, compared at 10-bit width. No counter value >= H_TOTAL or >= V_TOTAL is ever reachable.
- Internal structure: no FSM beyond the two wrap counters. Sync/blank decode is pure compare logic feeding the output registers.

Test Plan:
- Reset, then tick=1 every cycle -> after 656 ticks hsync=0; low for exactly 96 ticks (h=656..751); video_on falls at h=640; pixel_x reads 799 then 0 with pixel_y 0->1.
- tick pulsed once every 1000 clk_in cycles (divider rate) -> pixel_x increments by exactly 1 per tick and holds constant for the 999 non-tick cycles; frame_start stays 0.
- Run 420000 ticks from reset -> frame_start high for exactly one clk_in cycle when (799,524)->(0,0); vsync low exactly for v=490..491 (1600 ticks); video_on=0 for all v>=480.
- Assert reset for one cycle at (h=300,v=200) with tick=1 -> next cycle pixel_x=0, pixel_y=0, video_on=1, hsync=vsync=1, frame_start=0; counting resumes from 0.
- SYNC_POL=1 build, tick every cycle -> hsync high only at h=656..751, vsync high only at v=490..491, both 0 out of reset.
- Random tick gaps (0–7 idle cycles) over two full frames -> each output trace matches a reference model indexed by tick count; exactly two frame_start pulses.
